seq_ctrl: RTL

- Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator machine.
- Owns the single von Neumann memory port. It fetches each instruction through a req/ack handshake, latches the 3-bit opcode, and then drives the datapath strobes for execute and memory phases.
- Provides run/step debug control and a bus-timeout watchdog.
- Sits between the memory interface and the datapath (RF, ALU, accumulator, PC).

---
 rtl/seq_ctrl_pkg.sv | 47 ++++
 rtl/seq_decode.sv | 65 ++++++
 rtl/seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seq_ctrl_pkg
// Shared constants and types for the accumulator-machine sequencer:
//   - 3-bit opcode encodings (OP_ACM .. OP_LW)
//   - 2-bit ALU control encodings (ALU_ADD .. ALU_LT)
//   - FSM state encodings (legacy-compatible localparam constants)
//   - exec_ctl_t: the EXEC/MEM strobe set produced by seq_decode
// -----------------------------------------------------------------------------
package seq_ctrl_pkg;

   // Instruction opcodes, field inst[7:5]
   localparam logic [2:0] OP_ACM  = 3'b000;
   localparam logic [2:0] OP_ACMI = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_BNZ  = 3'b100;
   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SW   = 3'b110;
   localparam logic [2:0] OP_LW   = 3'b111;

   // ALU control
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_NAND = 2'b01;
   localparam logic [1:0] ALU_NZ   = 2'b10;
   localparam logic [1:0] ALU_LT   = 2'b11;

   // Sequencer states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_ERR    = 3'd5;

   // Strobe set implied by the latched opcode
   typedef struct packed {
      logic       acc_we;      // accumulator write in EXEC
      logic       sel_acc_in;  // accumulator source: 1 = immediate
      logic       reg_we;      // RF write in EXEC
      logic       sel_alu_in;  // ALU B operand: 1 = RF
      logic [1:0] cntr_alu;    // ALU function
      logic       branch;      // BNZ: pc_load follows alu_nz
      logic       mem_op;      // needs a MEM phase (SW/LW)
      logic       mem_wr;      // MEM phase is a store
   } exec_ctl_t;

endpackage

// File: rtl/seq_decode.sv
// -----------------------------------------------------------------------------
// seq_decode
// Purely combinational opcode decoder. Maps the latched opcode to the
// strobe set used in EXEC (and the MEM-phase kind for SW/LW). The
// sequencer FSM gates these strobes by state.
// Ports:
//   opcode  in   3  latched instruction opcode
//   ctl     out  exec_ctl_t  decoded strobe set
// -----------------------------------------------------------------------------
module seq_decode
   import seq_ctrl_pkg::*;
(
   input  logic [2:0] opcode,
   output exec_ctl_t  ctl
);

   // Opcode to strobe-set table
   always_comb begin
      ctl = '0;
      case (opcode)
         OP_ACM: begin
            ctl.acc_we     = 1'b1;
            ctl.sel_acc_in = 1'b0;
         end
         OP_ACMI: begin
            ctl.acc_we     = 1'b1;
            ctl.sel_acc_in = 1'b1;
         end
         OP_ADD: begin
            ctl.reg_we     = 1'b1;
            ctl.sel_alu_in = 1'b1;
            ctl.cntr_alu   = ALU_ADD;
         end
         OP_NAND: begin
            ctl.reg_we     = 1'b1;
            ctl.sel_alu_in = 1'b1;
            ctl.cntr_alu   = ALU_NAND;
         end
         OP_BNZ: begin
            // Compare accumulator against zero; the flag is also written back.
            ctl.reg_we     = 1'b1;
            ctl.sel_alu_in = 1'b0;
            ctl.cntr_alu   = ALU_NZ;
            ctl.branch     = 1'b1;
         end
         OP_SLT: begin
            ctl.reg_we     = 1'b1;
            ctl.sel_alu_in = 1'b1;
            ctl.cntr_alu   = ALU_LT;
         end
         OP_SW: begin
            ctl.mem_op = 1'b1;
            ctl.mem_wr = 1'b1;
         end
         OP_LW: begin
            ctl.mem_op = 1'b1;
            ctl.mem_wr = 1'b0;
         end
         default: begin
            ctl = '0;
         end
      endcase
   end

endmodule

// File: rtl/seq_ctrl.sv
// -----------------------------------------------------------------------------
// seq_ctrl
// Fetch/decode/execute sequencer for the 8-bit accumulator machine. Owns the
// single memory port (req/ack), latches the opcode, drives datapath strobes,
// supports run/step debug control and a bus-timeout watchdog.
// Ports:
//   clk, rst_n          clock (rising) / async active-low reset
//   run, step           free-run level / single-instruction pulse (halted)
//   mem_ack             memory completes current request
//   mem_rdata_op [2:0]  opcode field of memory read data
//   alu_nz              ALU "!= 0" result for BNZ
//   mem_req, mem_we, sel_mem_in          memory port controls
//   ir_we, pc_inc, pc_load               IR / PC controls
//   reg_we, acc_we, sel_acc_in, sel_alu_in, lw, cntr_alu [1:0]  datapath
//   retire, halted, bus_err              status
// Outputs are combinational from state, opcode, mem_ack and alu_nz.
// -----------------------------------------------------------------------------
module seq_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int TO_W   = 4,
   parameter int TO_MAX = 15
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       step,
   input  logic       mem_ack,
   input  logic [2:0] mem_rdata_op,
   input  logic       alu_nz,
   output logic       mem_req,
   output logic       mem_we,
   output logic       sel_mem_in,
   output logic       ir_we,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       reg_we,
   output logic       acc_we,
   output logic       sel_acc_in,
   output logic       sel_alu_in,
   output logic       lw,
   output logic [1:0] cntr_alu,
   output logic       retire,
   output logic       halted,
   output logic       bus_err
);

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_MAX);

   logic [2:0]      state_r;
   logic [2:0]      state_nxt_s;
   logic [2:0]      opcode_r;
   logic [TO_W-1:0] cnt_r;
   logic [TO_W-1:0] cnt_nxt_s;
   logic            single_r;
   logic            single_nxt_s;
   logic [2:0]      bound_state_s;
   exec_ctl_t       ctl_s;

   seq_decode u_decode (
      .opcode (opcode_r),
      .ctl    (ctl_s)
   );

   // The ALU function follows the latched opcode, so it holds between EXECs.
   assign cntr_alu = ctl_s.cntr_alu;

   // Where to go when an instruction completes: keep running only in
   // free-run mode; a step-launched instruction always returns to IDLE.
   assign bound_state_s = (run && !single_r) ? ST_FETCH : ST_IDLE;

   // Next-state and strobe decode
   always_comb begin
      state_nxt_s  = state_r;
      single_nxt_s = single_r;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      sel_mem_in   = 1'b0;
      ir_we        = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      reg_we       = 1'b0;
      acc_we       = 1'b0;
      sel_acc_in   = 1'b0;
      sel_alu_in   = 1'b0;
      lw           = 1'b0;
      retire       = 1'b0;
      halted       = 1'b0;
      bus_err      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            halted = 1'b1;
            if (run || step) begin
               state_nxt_s  = ST_FETCH;
               // Single-step only when not free-running (step ignored if run=1).
               single_nxt_s = ~run;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            mem_req    = 1'b1;
            sel_mem_in = 1'b0;
            if (mem_ack) begin
               ir_we       = 1'b1;
               pc_inc      = 1'b1;
               state_nxt_s = ST_DECODE;
            end else if (cnt_r == TO_LIM) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            state_nxt_s = ST_EXEC;
         end
         ST_EXEC: begin
            acc_we     = ctl_s.acc_we;
            sel_acc_in = ctl_s.sel_acc_in;
            reg_we     = ctl_s.reg_we;
            sel_alu_in = ctl_s.sel_alu_in;
            pc_load    = ctl_s.branch & alu_nz;
            if (ctl_s.mem_op) begin
               state_nxt_s = ST_MEM;
            end else begin
               retire       = 1'b1;
               state_nxt_s  = bound_state_s;
               single_nxt_s = 1'b0;
            end
         end
         ST_MEM: begin
            mem_req    = 1'b1;
            sel_mem_in = 1'b1;
            mem_we     = ctl_s.mem_wr;
            lw         = ~ctl_s.mem_wr;
            if (mem_ack) begin
               // Load data is only valid in the ack cycle.
               reg_we       = ~ctl_s.mem_wr;
               retire       = 1'b1;
               state_nxt_s  = bound_state_s;
               single_nxt_s = 1'b0;
            end else if (cnt_r == TO_LIM) begin
               state_nxt_s = ST_ERR;
            end else begin
               state_nxt_s = ST_MEM;
            end
         end
         ST_ERR: begin
            // Terminal until reset; all strobes stay low.
            bus_err     = 1'b1;
            state_nxt_s = ST_ERR;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Ack-timeout counter: counts waiting cycles of one request only
   always_comb begin
      if ((state_r == ST_FETCH || state_r == ST_MEM) && !mem_ack &&
          (state_nxt_s == state_r)) begin
         cnt_nxt_s = cnt_r + TO_W'(1);
      end else begin
         cnt_nxt_s = {TO_W{1'b0}};
      end
   end

   // State, opcode, timeout and single-step flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         opcode_r <= 3'b000;
         cnt_r    <= {TO_W{1'b0}};
         single_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         opcode_r <= ir_we ? mem_rdata_op : opcode_r;
         cnt_r    <= cnt_nxt_s;
         single_r <= single_nxt_s;
      end
   end

endmodule
